instruction_fetch_stage: RTL and testbench

//   IF stage of the 5-stage MIPS pipeline. Owns the program counter and drives the word address into instruction_memory.

---
 rtl/instruction_fetch_stage_pkg.sv | 34 +++
 rtl/instruction_fetch_stage_if.sv | 29 ++
 rtl/instruction_fetch_stage_if_id_register.sv | 27 ++
 rtl/instruction_fetch_stage.sv | 93 +++++++++
 tb/tb_instruction_fetch_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Purpose : shared types and constants for the MIPS IF stage and its IF/ID register.
// Contents: word width, NOP encoding, PC step, per-edge fetch operation enum,
//           IF/ID payload struct and a word-alignment helper.
package instruction_fetch_stage_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam logic [WORD_W-1:0] MIPS_NOP     = 32'h0000_0000;
   localparam logic [WORD_W-1:0] MIPS_PC_STEP = 32'd4;

   // Action taken by the stage on the coming rising edge.
   typedef enum logic [1:0] {
      OP_RUN   = 2'd0,
      OP_HOLD  = 2'd1,
      OP_FLUSH = 2'd2
   } fetch_op_e;

   // Contents of the IF/ID pipeline register.
   typedef struct packed {
      logic [WORD_W-1:0] instruction;
      logic [WORD_W-1:0] pc_plus4;
      logic              valid;
   } if_id_payload_t;

   // A bubble and the reset value are the same thing: a NOP marked invalid.
   localparam if_id_payload_t IF_ID_BUBBLE = '{instruction: MIPS_NOP,
                                               pc_plus4:    '0,
                                               valid:       1'b0};

   // Byte addresses are forced onto word boundaries.
   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Purpose : bus bundle between the IF stage and its surroundings
//           (hazard unit, redirect source, instruction memory, ID stage).
// master  : the IF stage (drives imem_address, pc and the IF/ID outputs).
// slave   : the environment (drives stall, redirect, redirect_target, imem_data).
interface instruction_fetch_stage_if
   import instruction_fetch_stage_pkg::*;
#(
   parameter int unsigned SIZE_EXP2 = 10
);
   logic                 stall;
   logic                 redirect;
   logic [WORD_W-1:0]    redirect_target;
   logic [SIZE_EXP2-1:0] imem_address;
   logic [WORD_W-1:0]    imem_data;
   logic [WORD_W-1:0]    pc;
   logic [WORD_W-1:0]    if_id_instruction;
   logic [WORD_W-1:0]    if_id_pc_plus4;
   logic                 if_id_valid;

   modport master (
      input  stall, redirect, redirect_target, imem_data,
      output imem_address, pc, if_id_instruction, if_id_pc_plus4, if_id_valid
   );

   modport slave (
      output stall, redirect, redirect_target, imem_data,
      input  imem_address, pc, if_id_instruction, if_id_pc_plus4, if_id_valid
   );
endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// Purpose : IF/ID pipeline flop bank with flush/hold/load control and async reset.
// Ports   : clk, rst (async, active-high), flush (load a bubble, highest priority),
//           hold (keep contents), load (capture payload_in), payload_in, payload (registered).
module if_id_register
   import instruction_fetch_stage_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           hold,
   input  logic           load,
   input  if_id_payload_t payload_in,
   output if_id_payload_t payload
);

   // Flush beats hold beats load; with none asserted the contents stay put.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         payload <= IF_ID_BUBBLE;
      end else if (flush) begin
         payload <= IF_ID_BUBBLE;
      end else if (load && !hold) begin
         payload <= payload_in;
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Purpose : IF stage of the 5-stage MIPS pipeline. Owns the PC, drives the
//           instruction-memory word address and fills the IF/ID register.
// Ports   : system_clock, reset (async, active-high),
//           bus (master modport): stall, redirect, redirect_target, imem_data in;
//           imem_address (combinational from pc), pc, if_id_* out.
// Option  : FETCH_STATS_EN adds fetch_count / bubble_count outputs.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter int unsigned       SIZE_EXP2 = 10,
   parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000
) (
   input  logic                      system_clock,
   input  logic                      reset,
   instruction_fetch_stage_if.master bus
`ifdef FETCH_STATS_EN
   ,
   output logic [WORD_W-1:0]         fetch_count,
   output logic [WORD_W-1:0]         bubble_count
`endif
);

   localparam logic [WORD_W-1:0] RESET_PC_ALIGNED = {RESET_PC[WORD_W-1:2], 2'b00};

   fetch_op_e         op;
   logic [WORD_W-1:0] pc_q;
   logic [WORD_W-1:0] pc_d;
   logic [WORD_W-1:0] pc_plus4;
   if_id_payload_t    fetch_payload;
   if_id_payload_t    if_id_q;

   // Per-edge action: redirect overrides stall, stall overrides normal fetch.
   always_comb begin
      op            = OP_RUN;
      pc_plus4      = pc_q + MIPS_PC_STEP;
      pc_d          = pc_q;
      fetch_payload = '{instruction: bus.imem_data, pc_plus4: pc_plus4, valid: 1'b1};

      if (bus.redirect) begin
         op = OP_FLUSH;
      end else if (bus.stall) begin
         op = OP_HOLD;
      end

      case (op)
         OP_RUN:   pc_d = pc_plus4;
         OP_FLUSH: pc_d = word_align(bus.redirect_target);
         OP_HOLD:  pc_d = pc_q;
         default:  pc_d = pc_q;
      endcase
   end

   // Program counter.
   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC_ALIGNED;
      end else begin
         pc_q <= pc_d;
      end
   end

   if_id_register u_if_id (
      .clk        (system_clock),
      .rst        (reset),
      .flush      (op == OP_FLUSH),
      .hold       (op == OP_HOLD),
      .load       (op == OP_RUN),
      .payload_in (fetch_payload),
      .payload    (if_id_q)
   );

   // Word address wraps naturally by dropping the bits above the memory depth.
   assign bus.imem_address      = pc_q[SIZE_EXP2+1:2];
   assign bus.pc                = pc_q;
   assign bus.if_id_instruction = if_id_q.instruction;
   assign bus.if_id_pc_plus4    = if_id_q.pc_plus4;
   assign bus.if_id_valid       = if_id_q.valid;

`ifdef FETCH_STATS_EN
   // Fetches count loaded instructions; bubbles count stall and redirect edges.
   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         fetch_count  <= '0;
         bubble_count <= '0;
      end else if (op == OP_RUN) begin
         fetch_count  <= fetch_count + 32'd1;
      end else begin
         bubble_count <= bubble_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Purpose : self-checking bench for instruction_fetch_stage. A behavioural model
//           pushes the expected post-edge state into a scoreboard queue when the
//           inputs are driven; the entry is popped and compared after the edge.
//           A second instance with RESET_PC=0x100 checks the reset vector.
module tb_instruction_fetch_stage;
   import instruction_fetch_stage_pkg::*;

   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 1 << AW;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] fcnt;
      logic [31:0] bcnt;
   } exp_t;

   logic system_clock;
   logic reset;
   logic [31:0] mem [0:DEPTH-1];

   int compared   = 0;
   int mismatched = 0;
   exp_t sb_q[$];

   logic [31:0] m_pc, m_instr, m_pc4, m_fetch, m_bubble;
   logic        m_valid;

   instruction_fetch_stage_if #(.SIZE_EXP2(AW)) bus  ();
   instruction_fetch_stage_if #(.SIZE_EXP2(AW)) bus2 ();

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count, bubble_count, fetch_count2, bubble_count2;
`endif

   instruction_fetch_stage #(.SIZE_EXP2(AW), .RESET_PC(32'h0)) dut (
      .system_clock (system_clock),
      .reset        (reset),
      .bus          (bus.master)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count  (fetch_count),
      .bubble_count (bubble_count)
`endif
   );

   instruction_fetch_stage #(.SIZE_EXP2(AW), .RESET_PC(32'h100)) dut2 (
      .system_clock (system_clock),
      .reset        (reset),
      .bus          (bus2.master)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count  (fetch_count2),
      .bubble_count (bubble_count2)
`endif
   );

   // Combinational-read instruction memory shared by both instances.
   assign bus.imem_data  = mem[bus.imem_address];
   assign bus2.imem_data = mem[bus2.imem_address];
   assign bus2.stall           = 1'b0;
   assign bus2.redirect        = 1'b0;
   assign bus2.redirect_target = 32'h0;

   initial system_clock = 1'b0;
   always #5 system_clock = ~system_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_fetch = 32'h0; m_bubble = 32'h0;
   endtask

   // Called at a falling edge: drive inputs, predict, take one rising edge, compare.
   task automatic step(input logic s, input logic r, input logic [31:0] t);
      exp_t e;
      exp_t got;
      bus.stall = s; bus.redirect = r; bus.redirect_target = t;
      if (r) begin
         m_pc = {t[31:2], 2'b00}; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_bubble = m_bubble + 32'd1;
      end else if (s) begin
         m_bubble = m_bubble + 32'd1;
      end else begin
         m_instr = mem[m_pc[AW+1:2]];
         m_pc4   = m_pc + 32'd4;
         m_pc    = m_pc4;
         m_valid = 1'b1;
         m_fetch = m_fetch + 32'd1;
      end
      e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, fcnt: m_fetch, bcnt: m_bubble};
      sb_q.push_back(e);
      @(posedge system_clock);
      #1;
      got = sb_q.pop_front();
      check("pc",       bus.pc,                      got.pc);
      check("imem_adr", 32'(bus.imem_address),       32'(got.pc[AW+1:2]));
      check("instr",    bus.if_id_instruction,       got.instr);
      check("pc_plus4", bus.if_id_pc_plus4,          got.pc4);
      check("valid",    32'(bus.if_id_valid),        32'(got.valid));
`ifdef FETCH_STATS_EN
      check("fetch_cnt",  fetch_count,  got.fcnt);
      check("bubble_cnt", bubble_count, got.bcnt);
`endif
      @(negedge system_clock);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pc"},    bus.pc,                m_pc);
      check({tag, "_instr"}, bus.if_id_instruction, 32'h0);
      check({tag, "_pc4"},   bus.if_id_pc_plus4,    32'h0);
      check({tag, "_valid"}, 32'(bus.if_id_valid),  32'h0);
      check({tag, "_pc2"},   bus2.pc,               32'h100);
      check({tag, "_adr2"},  32'(bus2.imem_address), 32'd64);
`ifdef FETCH_STATS_EN
      check({tag, "_fcnt"},  fetch_count,  32'h0);
      check({tag, "_bcnt"},  bubble_count, 32'h0);
`endif
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
      mem[0]    = 32'h2008_0005;
      mem[1]    = 32'h2009_0003;
      mem[2]    = 32'h0109_5020;
      mem[8]    = 32'h8C0B_0020;
      mem[16]   = 32'h1234_5678;
      mem[64]   = 32'hCAFE_0040;
      mem[1023] = 32'hDEAD_03FF;

      bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 32'h0;
      reset = 1'b1;
      model_reset();
      #12;
      check_reset_state("rst");

      // Release reset on a falling edge; first edge after release fetches word 0.
      @(negedge system_clock);
      reset = 1'b0;

      // Straight-line fetch up to pc=8.
      step(1'b0, 1'b0, 32'h0);
      check("rpc_first_instr", bus2.if_id_instruction, 32'hCAFE_0040);
      check("rpc_first_pc4",   bus2.if_id_pc_plus4,    32'h104);
      check("rpc_pc",          bus2.pc,                32'h104);
      step(1'b0, 1'b0, 32'h0);

      // Two stall edges, then resume.
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
`ifdef FETCH_STATS_EN
      check("two_bubbles", bubble_count, 32'd2);
`endif
      step(1'b0, 1'b0, 32'h0);

      // Redirect to 0x40 squashes, then word 16 arrives.
      step(1'b0, 1'b1, 32'h40);
      step(1'b0, 1'b0, 32'h0);
      check("redir_word16", bus.if_id_instruction, 32'h1234_5678);

      // Redirect and stall together; target low bits dropped.
      step(1'b1, 1'b1, 32'h23);
      check("redir_stall_pc", bus.pc, 32'h20);
      step(1'b0, 1'b0, 32'h0);

      // Top of address space: address wrap and 32-bit pc wrap.
      step(1'b0, 1'b1, 32'hFFFF_FFFE);
      check("wrap_adr", 32'(bus.imem_address), 32'h3FF);
      step(1'b0, 1'b0, 32'h0);
      check("wrap_pc", bus.pc, 32'h0);

      // Random mix of stalls and redirects.
      for (int i = 0; i < 40; i++) begin
         logic rs, rr;
         rs = ($urandom_range(0, 3) == 0);
         rr = ($urandom_range(0, 4) == 0);
         step(rs, rr, $urandom_range(0, 32'hFFF));
      end

      // Reset asserted between edges takes effect with no clock.
      @(posedge system_clock);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_reset_state("midrst");
      @(negedge system_clock);
      reset = 1'b0;
      step(1'b0, 1'b0, 32'h0);
      check("post_rst_instr", bus.if_id_instruction, 32'h2008_0005);
      check("post_rst_rpc",   bus2.if_id_instruction, 32'hCAFE_0040);
      step(1'b0, 1'b0, 32'h0);

      if (sb_q.size() != 0) check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
